// File: rtl/cskip_pipe_adder.sv
// cskip_pipe_adder: pipelined carry-skip adder with valid/ready stream; define CSKIP_OVF_EN to add the ovf port
module cskip_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSKIP_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SW   = BLK * BPS;
  localparam int NSTG = WIDTH / SW;
  localparam int NOPS = (NSTG > 1) ? NSTG - 1 : 1;

  function automatic logic [SW:0] stage_add(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
    logic [SW-1:0] s;
    logic          c;
    logic          r;
    s = '0;
    c = ci;
    for (int j = 0; j < BPS; j++) begin
      r = c;
      for (int i = 0; i < BLK; i++) begin
        s[j*BLK+i] = x[j*BLK+i] ^ y[j*BLK+i] ^ r;
        r = (x[j*BLK+i] & y[j*BLK+i]) | (r & (x[j*BLK+i] ^ y[j*BLK+i]));
      end
      c = (&(x[j*BLK +: BLK] ^ y[j*BLK +: BLK])) ? c : r;
    end
    return {c, s};
  endfunction

  logic [NSTG-1:0]  w_rdy;
  logic             r_v   [NSTG];
  logic             r_c   [NSTG];
  logic [WIDTH-1:0] r_s   [NSTG];
  logic [WIDTH-1:0] r_a   [NOPS];
  logic [WIDTH-1:0] r_b   [NOPS];
  logic [WIDTH-1:0] w_a   [NSTG];
  logic [WIDTH-1:0] w_b   [NSTG];
  logic [WIDTH-1:0] w_sin [NSTG];
  logic             w_ci  [NSTG];
  logic             w_vin [NSTG];
  logic [SW:0]      w_add [NSTG];

  // Ready ripples back from the consumer so a full pipe can accept while draining
  always_comb begin : ready_chain
    logic w_up;
    w_rdy = '0;
    w_up  = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      w_rdy[k] = !r_v[k] | w_up;
      w_up     = w_rdy[k];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    if (k == 0) begin : g_src
      assign w_a[k]   = a;
      assign w_b[k]   = b;
      assign w_ci[k]  = cin;
      assign w_vin[k] = in_valid;
      assign w_sin[k] = '0;
    end else begin : g_src
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_ci[k]  = r_c[k-1];
      assign w_vin[k] = r_v[k-1];
      assign w_sin[k] = r_s[k-1];
    end
    assign w_add[k] = stage_add(w_a[k][SW-1:0], w_b[k][SW-1:0], w_ci[k]);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_s[k] <= '0;
      end else if (w_rdy[k]) begin
        r_v[k] <= w_vin[k];
        r_c[k] <= w_add[k][SW];
        r_s[k] <= w_sin[k] | (WIDTH'(w_add[k][SW-1:0]) << (k * SW));
      end
    end
    // Remaining operand bits are kept right-aligned so every stage adds its low SW bits
    if (k < NSTG - 1) begin : g_ops
      always_ff @(posedge clk) begin
        if (w_rdy[k]) begin
          r_a[k] <= w_a[k] >> SW;
          r_b[k] <= w_b[k] >> SW;
        end
      end
    end
  end

`ifdef CSKIP_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_rdy[NSTG-1]) r_ovf <= (w_a[NSTG-1][SW-1] == w_b[NSTG-1][SW-1]) & (w_add[NSTG-1][SW-1] != w_a[NSTG-1][SW-1]);
  end
  assign ovf = r_ovf;
`endif

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[NSTG-1];
  assign sum       = r_s[NSTG-1];
  assign cout      = r_c[NSTG-1];
endmodule

// File: tb/tb_cskip_pipe_adder.sv
// tb_cskip_pipe_adder: directed checks of latency, carry/skip paths, streaming, backpressure and reset
module tb_cskip_pipe_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        cout;
  logic [31:0] sum;
`ifdef CSKIP_OVF_EN
  logic        ovf;
`endif
  int checks = 0;
  int failures = 0;
  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic [32:0] vexp [8];

  always #5 clk = ~clk;

  cskip_pipe_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CSKIP_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic single(input logic [31:0] xa, input logic [31:0] xb, input logic xc, output int n);
    out_ready = 1'b1;
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h want=00000000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
`ifdef CSKIP_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_carry_chain();
    int n;
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL carry_latency got=%0d want=3 edges after accept", n); end
    checks++; if (sum !== 32'h0) begin failures++; $display("FAIL carry_sum got=%h want=00000000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL carry_cout got=%b want=1", cout); end
`ifdef CSKIP_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL carry_ovf got=%b want=0", ovf); end
`endif
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL carry_no_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_skip();
    int n;
    single(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL skip1_latency got=%0d want=3", n); end
    checks++; if ({cout, sum} !== 33'h1_0000_0000) begin failures++; $display("FAIL skip1_result got=%h want=100000000", {cout, sum}); end
    @(posedge clk); #1;
    single(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL skip0_latency got=%0d want=3", n); end
    checks++; if ({cout, sum} !== 33'h0_FFFF_FFFF) begin failures++; $display("FAIL skip0_result got=%h want=0ffffffff", {cout, sum}); end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    int n;
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL ovf_latency got=%0d want=3", n); end
    checks++; if ({cout, sum} !== 33'h0_8000_0000) begin failures++; $display("FAIL ovf_result got=%h want=080000000", {cout, sum}); end
`ifdef CSKIP_OVF_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", ovf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    logic exp_v;
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      in_valid = (t < 8);
      if (t < 8) begin a = va[t]; b = vb[t]; cin = vc[t]; end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready t=%0d got=%b want=1", t, in_ready); end
      @(posedge clk); #1;
      exp_v = (t >= 3 && t < 11);
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL stream_valid t=%0d got=%b want=%b", t, out_valid, exp_v); end
      if (out_valid === 1'b1 && idx < 8) begin
        checks++; if ({cout, sum} !== vexp[idx]) begin failures++; $display("FAIL stream_data idx=%0d got=%h want=%h", idx, {cout, sum}, vexp[idx]); end
        idx++;
      end
    end
    in_valid = 1'b0;
    checks++; if (idx !== 8) begin failures++; $display("FAIL stream_count got=%0d want=8", idx); end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int idx = 0;
    logic rdy;
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1; a = va[nacc & 7]; b = vb[nacc & 7]; cin = vc[nacc & 7];
      rdy = in_ready;
      checks++; if (rdy !== (t < 4)) begin failures++; $display("FAIL bp_in_ready t=%0d got=%b want=%b", t, rdy, (t < 4)); end
      @(posedge clk); #1;
      if (rdy === 1'b1) nacc++;
    end
    in_valid = 1'b0;
    checks++; if (nacc !== 4) begin failures++; $display("FAIL bp_accepted got=%0d want=4", nacc); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
    checks++; if ({cout, sum} !== vexp[0]) begin failures++; $display("FAIL bp_hold_data got=%h want=%h", {cout, sum}, vexp[0]); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_full_drain_ready got=%b want=1", in_ready); end
    for (int t = 0; t < 10 && idx < 4; t++) begin
      if (out_valid === 1'b1) begin
        checks++; if ({cout, sum} !== vexp[idx]) begin failures++; $display("FAIL bp_drain idx=%0d got=%h want=%h", idx, {cout, sum}, vexp[idx]); end
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++; if (idx !== 4) begin failures++; $display("FAIL bp_drain_count got=%0d want=4", idx); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b0;
    for (int t = 5; t < 8; t++) begin
      in_valid = 1'b1; a = va[t]; b = vb[t]; cin = vc[t];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({out_valid, cout, sum} !== {1'b1, vexp[5]}) begin failures++; $display("FAIL rst_pre got=%h want=%h", {out_valid, cout, sum}, {1'b1, vexp[5]}); end
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    checks++; if ({cout, sum} !== 33'h0) begin failures++; $display("FAIL rst_mid_data got=%h want=000000000", {cout, sum}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_rel_valid got=%b want=0", out_valid); end
    single(va[0], vb[0], vc[0], n);
    checks++; if (n !== 3) begin failures++; $display("FAIL rst_fresh_latency got=%0d want=3", n); end
    checks++; if ({cout, sum} !== vexp[0]) begin failures++; $display("FAIL rst_fresh_data got=%h want=%h", {cout, sum}, vexp[0]); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_stale got=%b want=0", out_valid); end
  endtask

  initial begin
    va = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h0000_0000, 32'h7FFF_0000};
    vb = '{32'h0000_0002, 32'h8765_4321, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0000_0001, 32'h0000_0000, 32'h0000_FFFF};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vexp = '{33'h0_0000_0003, 33'h0_9999_9999, 33'h1_FFFF_FFFF, 33'h1_0000_0000,
             33'h1_0000_0000, 33'h0_DEAD_BEF0, 33'h0_0000_0001, 33'h0_8000_0000};
    test_reset();
    test_carry_chain();
    test_skip();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/cskip_pipe_adder.md
# cskip_pipe_adder

Parametrised, pipelined carry-skip adder: the successor to our fixed 16-bit, 4-bit-block combinational carry-skip adder. Operand width, skip-block size and blocks-per-pipeline-stage are all parameters. Each stage resolves its blocks with ripple-carry plus a per-block propagate-skip mux, then registers the partial sum, carry and remaining operand bits. The block sits on a valid/ready stream between operand producers and result consumers, with full backpressure and in-order delivery.

## Interface
- `WIDTH`, 32, operand/sum width in bits
- `BLK`, 4, bits per carry-skip block
- `BPS`, 2, skip blocks resolved per pipeline stage; `WIDTH % (BLK*BPS) == 0` is required; `NSTG = WIDTH/(BLK*BPS)`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  adder can accept operands
- `a`  in  WIDTH  operand A (unsigned/two's complement)
- `b`  in  WIDTH  operand B
- `cin`  in  1  carry in
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  WIDTH  a+b+cin, modulo 2^WIDTH
- `cout`  out  1  carry out of MSB
- `ovf`  out  1  signed overflow (only with `CSKIP_OVF_EN`)

## Operation
- Block rule, per BLK-bit block j with carry-in c_j: `P_j = &(a_j ^ b_j)`; ripple full adders produce sum bits and ripple carry r_j; `c_{j+1} = P_j ? c_j : r_j`. Sum bits always come from the ripple.
- Stage k holds: `v[k]`, accumulated sum bits [0 .. (k+1)*BLK*BPS-1], carry out of its last block, and the unprocessed upper bits of a and b.
- Stage 0 computes blocks 0..BPS-1 from `a`, `b`, `cin`. Stage k computes blocks k*BPS..(k+1)*BPS-1 from its predecessor's registers.
- Advance rule: `rdy[NSTG-1] = !v[NSTG-1] | out_ready`; `rdy[k] = !v[k] | rdy[k+1]`; `in_ready = rdy[0]`.
- Stage k loads when `rdy[k]`. Its `v[k]` takes the upstream valid: `in_valid` for stage 0, `v[k-1]` otherwise.
- Bubbles collapse. A stalled stage holds its contents unchanged.
- `sum`, `cout` and `ovf` are driven directly from the stage NSTG-1 registers. `out_valid = v[NSTG-1]`.
- Results are delivered in acceptance order. No transaction is dropped or duplicated.
- Reset: all `v[k]` go to 0 immediately. `out_valid` = 0 and `sum` = 0, `cout` = 0, `ovf` = 0. `in_ready` = 1 once reset is released.
- Reset mid-operation discards every in-flight transaction. There is no partial flush.
- No operand registers exist on the input side. `a`, `b` and `cin` are sampled only on the edge where `in_valid & in_ready`.
- `sum`, `cout` and `ovf` are stable while `out_valid & !out_ready`.

## Timing
- Latency is NSTG cycles: operands accepted in cycle c are presented with `out_valid` = 1 in cycle c+NSTG if the pipe is not stalled.
- With the default configuration, NSTG = 4.
- Throughput is one result per cycle with `out_ready` held high.
- Capacity is NSTG transactions. With `out_ready` = 0 and continuous input, `in_ready` falls in the cycle after the NSTG-th acceptance.
- Simultaneous accept and drain while full: when `out_ready` = 1 with all stages valid, `in_ready` = 1 in the same cycle (combinational ready chain), so there is no throughput loss.
- Combinational path per stage: BPS·BLK full-adder ripple worst case, or ripple plus skip mux.
- Combinational path through handshake: the `out_ready` → `in_ready` chain passes through NSTG gates.

## Configuration
- Macro: `CSKIP_OVF_EN`.
- Defined: the `ovf` port exists. The last stage also registers the operand sign bits, and `ovf = (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1])`. `ovf` is pipelined in lockstep with `sum` and reset to 0.
- Undefined: no `ovf` port and no sign-bit registers. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, BLK=4, BPS=2, NSTG=4.
- Carry through all blocks: `a=0xFFFFFFFF`, `b=0x00000001`, `cin=0`, accepted cycle c → `out_valid` in cycle c+4, `sum=0x00000000`, `cout=1`, `ovf=0`.
- Full-propagate skip path: `a=0xAAAAAAAA`, `b=0x55555555`, `cin=1` → `sum=0x00000000`, `cout=1`. With `cin=0` → `sum=0xFFFFFFFF`, `cout=0`.
- Signed overflow (`CSKIP_OVF_EN`): `a=0x7FFFFFFF`, `b=0x00000001`, `cin=0` → `sum=0x80000000`, `cout=0`, `ovf=1`.
- Streaming: 8 back-to-back random pairs with `out_ready=1` → 8 results on consecutive cycles starting at c+4, in order, matching the reference model a+b+cin.
- Backpressure: hold `out_ready=0` with `in_valid=1` → exactly 4 accepted, then `in_ready=0`. Outputs are stable across the stall. Releasing `out_ready` drains in order with no loss.
- Reset mid-stream: assert `rst_n=0` with 3 transactions in flight → `out_valid=0` and `sum=0` immediately. After release, `in_ready=1` and a fresh transaction emerges 4 cycles after acceptance.
